// File: rtl/fir_pkg.sv
// Shared constants and FSM state type for the FIR tap sequencer, the
// shared shift-add multiplier and the filter top level.
package fir_pkg;

  localparam int FIR_TAPS = 8;   // number of taps, power of two, >= 2
  localparam int FIR_DW   = 14;  // sample width
  localparam int FIR_CW   = 4;   // coefficient width
  localparam int FIR_PW   = 18;  // multiplier product width
  localparam int FIR_MLAT = 3;   // multiplier latency in cycles
  localparam int FIR_AW   = FIR_PW + $clog2(FIR_TAPS);  // accumulator width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } fir_state_e;

  // Width of a counter that must reach max(taps, mlat) - 1; the same
  // counter walks the taps in ISSUE and times the drain in DRAIN.
  function automatic int fir_cnt_width(input int taps, input int mlat);
    int span;
    span = (taps > mlat) ? taps : mlat;
    return (span > 2) ? $clog2(span) : 1;
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Sample delay line: x[0] takes the new sample on a shift, older samples
// move one slot down and the oldest drops off. One indexed read port.
module fir_delay_line #(
  parameter int TAPS = 8,
  parameter int DW   = 14
) (
  input  logic                     clk,
  input  logic                     rst,       // synchronous, active-low
  input  logic                     shift_en,
  input  logic [DW-1:0]            din,
  input  logic [$clog2(TAPS)-1:0]  rd_idx,
  output logic [DW-1:0]            rd_data
);

  logic [DW-1:0] x_q [TAPS];
  logic [DW-1:0] x_d [TAPS];

  // Next contents: hold, or shift the new sample in at the head.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      x_d[k] = x_q[k];
    end
    if (shift_en) begin
      x_d[0] = din;
      for (int k = 1; k < TAPS; k++) begin
        x_d[k] = x_q[k-1];
      end
    end
  end

  // Register the delay line; reset empties it so a new pass starts clean.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= x_d[k];
      end
    end
  end

  assign rd_data = x_q[rd_idx];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR control: accepts one sample, issues one
// (sample, coefficient) pair per cycle to the shared multiplier, then
// accumulates the returning products and emits one filtered result.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS = FIR_TAPS,
  parameter int DW   = FIR_DW,
  parameter int CW   = FIR_CW,
  parameter int PW   = FIR_PW,
  parameter int AW   = PW + $clog2(TAPS),
  parameter int MLAT = FIR_MLAT
) (
  input  logic                     clk,
  input  logic                     rst,        // synchronous, active-low
  input  logic                     in_valid,
  input  logic [DW-1:0]            in_data,
  output logic                     in_ready,
  input  logic                     coe_wr,
  input  logic [$clog2(TAPS)-1:0]  coe_addr,
  input  logic [CW-1:0]            coe_wdata,
  output logic [DW-1:0]            mult_data,
  output logic [CW-1:0]            mult_coe,
  input  logic [PW-1:0]            mult_fltd,
  output logic                     out_valid,
  output logic [AW-1:0]            out_data
);

  localparam int AIW = $clog2(TAPS);
  localparam int IW  = fir_cnt_width(TAPS, MLAT);
  localparam logic [IW-1:0] LAST_TAP   = IW'(TAPS - 1);
  localparam logic [IW-1:0] LAST_DRAIN = IW'(MLAT - 1);

  fir_state_e      state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [AW-1:0]   out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic [MLAT-1:0] vpipe_q, vpipe_d;
  logic [CW-1:0]   c_q [TAPS];
  logic [CW-1:0]   c_d [TAPS];

  logic            accept;
  logic            issuing;
  logic [AIW-1:0]  tap_idx;
  logic [DW-1:0]   tap_sample;
  logic [AW-1:0]   prod_ext;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign issuing  = (state_q == ISSUE);
  assign tap_idx  = idx_q[AIW-1:0];
  assign prod_ext = {{(AW-PW){1'b0}}, mult_fltd};

  fir_delay_line #(
    .TAPS (TAPS),
    .DW   (DW)
  ) u_delay_line (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .din      (in_data),
    .rd_idx   (tap_idx),
    .rd_data  (tap_sample)
  );

  // Multiplier operands are forced to zero outside ISSUE so the shared
  // multiplier produces zeros whenever no pass is running.
  assign mult_data = issuing ? tap_sample     : '0;
  assign mult_coe  = issuing ? c_q[tap_idx]   : '0;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Next-state logic: FSM, tap/drain counter, product tracking and
  // accumulation, coefficient writes (IDLE only) and result capture.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    // Bit k set means a product issued k+1 cycles ago; the top bit marks
    // the cycle in which that product is present on mult_fltd.
    vpipe_d     = (vpipe_q << 1) | MLAT'(issuing);
    for (int k = 0; k < TAPS; k++) begin
      c_d[k] = c_q[k];
    end

    if (vpipe_q[MLAT-1]) begin
      acc_d = acc_q + prod_ext;
    end

    case (state_q)
      IDLE: begin
        if (coe_wr) begin
          c_d[coe_addr] = coe_wdata;
        end
        if (accept) begin
          state_d = ISSUE;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      ISSUE: begin
        if (idx_q == LAST_TAP) begin
          state_d = DRAIN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DRAIN: begin
        if (idx_q == LAST_DRAIN) begin
          // The final product arrives in this cycle, so fold it in directly.
          state_d     = IDLE;
          idx_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = acc_q + prod_ext;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State registers; reset aborts any pass in flight without a result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      vpipe_q     <= '0;
      for (int k = 0; k < TAPS; k++) begin
        c_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      vpipe_q     <= vpipe_d;
      for (int k = 0; k < TAPS; k++) begin
        c_q[k] <= c_d[k];
      end
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed-plus-random bench for fir_tap_sequencer with a behavioural
// stand-in for the shared multiplier and a sum-of-products filter model.
module tb_fir_tap_sequencer;
  import fir_pkg::*;

  localparam int TAPS = FIR_TAPS;
  localparam int DW   = FIR_DW;
  localparam int CW   = FIR_CW;
  localparam int PW   = FIR_PW;
  localparam int AW   = FIR_AW;
  localparam int MLAT = FIR_MLAT;
  localparam int PASS = TAPS + MLAT + 1;   // accept-to-result latency

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic [DW-1:0]           in_data;
  logic                    in_ready;
  logic                    coe_wr;
  logic [$clog2(TAPS)-1:0] coe_addr;
  logic [CW-1:0]           coe_wdata;
  logic [DW-1:0]           mult_data;
  logic [CW-1:0]           mult_coe;
  logic [PW-1:0]           mult_fltd;
  logic                    out_valid;
  logic [AW-1:0]           out_data;

  fir_tap_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .coe_wr    (coe_wr),
    .coe_addr  (coe_addr),
    .coe_wdata (coe_wdata),
    .mult_data (mult_data),
    .mult_coe  (mult_coe),
    .mult_fltd (mult_fltd),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: product appears MLAT cycles after issue, flushed by rst.
  logic [PW-1:0] prod_in;
  logic [PW-1:0] mpipe [MLAT];
  assign prod_in   = PW'(mult_data) * PW'(mult_coe);
  assign mult_fltd = mpipe[MLAT-1];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < MLAT; i++) mpipe[i] <= '0;
    end else begin
      mpipe[0] <= prod_in;
      for (int i = 1; i < MLAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end

  // Filter model: y = sum c[k] * x[k], x[0] newest.
  int          c_m [TAPS];
  int          x_m [TAPS];
  logic [AW-1:0] exp_pend;
  int          n_cmp;
  int          n_bad;

  int            n_acc, last_acc, ov_seen, cyc;
  logic [AW-1:0] obs;

  function automatic int model_out();
    int sum = 0;
    for (int k = 0; k < TAPS; k++) sum += c_m[k] * x_m[k];
    return sum;
  endfunction

  task automatic reset_model();
    for (int k = 0; k < TAPS; k++) begin
      c_m[k] = 0;
      x_m[k] = 0;
    end
  endtask

  task automatic push_sample(input logic [DW-1:0] s);
    for (int k = TAPS - 1; k > 0; k--) x_m[k] = x_m[k-1];
    x_m[0]   = int'(s);
    exp_pend = AW'(model_out());
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    while (in_ready !== 1'b1 && g < 3 * PASS) begin
      step();
      g++;
    end
    if (g >= 3 * PASS) check({tag, "_ready_timeout"}, in_ready, 1);
  endtask

  task automatic write_coe(input int a, input int v);
    wait_idle("coe");
    coe_wr    = 1'b1;
    coe_addr  = a[$clog2(TAPS)-1:0];
    coe_wdata = v[CW-1:0];
    step();
    coe_wr = 1'b0;
    c_m[a] = v;
  endtask

  // Present one sample for a single edge; returns in cycle 1 of the pass.
  task automatic send(input logic [DW-1:0] s);
    wait_idle("send");
    in_valid = 1'b1;
    in_data  = s;
    step();
    in_valid = 1'b0;
    push_sample(s);
  endtask

  // Follow a pass from cycle `start` to its result and the cycle after.
  task automatic collect(input string tag, input int start, output logic [AW-1:0] res);
    int  c = start;
    bit  busy_ok = 1'b1;
    while (out_valid !== 1'b1 && c < 3 * PASS) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      step();
      c++;
    end
    check({tag, "_latency"}, c, PASS);
    check({tag, "_busy"}, busy_ok, 1);
    check({tag, "_ready"}, in_ready, 1);
    check({tag, "_data"}, out_data, exp_pend);
    res = out_data;
    step();
    check({tag, "_pulse"}, out_valid, 0);
    check({tag, "_hold"}, out_data, exp_pend);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b0; in_valid = 1'b0; in_data = '0;
    coe_wr = 1'b0; coe_addr = '0; coe_wdata = '0;
    reset_model();
    exp_pend = '0;

    // Reset state, rst held low for three edges
    repeat (3) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_mult_coe", mult_coe, 0);
    check("rst_mult_data", mult_data, 0);
    rst = 1'b1;
    step();

    // Impulse response with c[k] = k+1
    for (int k = 0; k < TAPS; k++) write_coe(k, k + 1);
    for (int i = 0; i <= TAPS; i++) begin
      send((i == 0) ? DW'(100) : DW'(0));
      collect("imp", 1, obs);
      check("imp_val", obs, (i < TAPS) ? 100 * (i + 1) : 0);
    end

    // Full scale: no wrap at the largest possible sum
    for (int k = 0; k < TAPS; k++) write_coe(k, 15);
    for (int i = 0; i < TAPS; i++) begin
      send(DW'(16383));
      collect("full", 1, obs);
    end
    check("full_max", obs, 1965960);

    // Back-to-back with in_valid held high
    for (int k = 0; k < TAPS; k++) write_coe(k, int'($urandom_range(0, 15)));
    n_acc = 0; last_acc = 0; ov_seen = 0; cyc = 0;
    in_valid = 1'b1;
    in_data  = DW'($urandom);
    while (n_acc < 6 && cyc < 10 * PASS) begin
      if (out_valid === 1'b1) ov_seen++;
      if (in_ready === 1'b1) begin
        if (n_acc > 0) begin
          check("b2b_gap", cyc - last_acc, PASS);
          check("b2b_ovalid", out_valid, 1);
          check("b2b_data", out_data, exp_pend);
        end
        push_sample(in_data);
        last_acc = cyc;
        n_acc++;
      end
      step();
      cyc++;
      in_data = DW'($urandom);
    end
    in_valid = 1'b0;
    check("b2b_count", n_acc, 6);
    check("b2b_pulses", ov_seen, 5);
    collect("b2b_last", 1, obs);

    // Coefficient writes are ignored outside IDLE
    rst = 1'b0; step(); rst = 1'b1; reset_model();
    for (int k = 0; k < TAPS; k++) write_coe(k, k + 1);
    send(DW'(100));
    coe_wr = 1'b1; coe_addr = '0; coe_wdata = '0;
    step();
    coe_wr = 1'b0;
    collect("gate_busy", 2, obs);
    check("gate_busy_val", obs, 100);
    for (int i = 0; i < TAPS; i++) begin
      send(DW'(0));
      collect("gate_flush", 1, obs);
    end
    write_coe(0, 0);
    send(DW'(100));
    collect("gate_idle", 1, obs);
    check("gate_idle_val", obs, 0);
    send(DW'(0));
    collect("gate_next", 1, obs);
    check("gate_next_val", obs, 200);

    // Reset in cycle 5 of a pass aborts it and clears the delay line
    send(DW'($urandom));
    repeat (4) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    reset_model();
    exp_pend = '0;
    ov_seen = 0;
    repeat (2 * PASS) begin
      if (out_valid !== 1'b0) ov_seen++;
      step();
    end
    check("abort_no_valid", ov_seen, 0);
    check("abort_data", out_data, 0);
    check("abort_ready", in_ready, 1);
    for (int k = 0; k < TAPS; k++) write_coe(k, k + 1);
    for (int i = 0; i < TAPS; i++) begin
      send((i == 0) ? DW'(100) : DW'(0));
      collect("abort_imp", 1, obs);
      check("abort_imp_val", obs, 100 * (i + 1));
    end

    // Random coefficients and samples with occasional IDLE rewrites
    for (int k = 0; k < TAPS; k++) write_coe(k, int'($urandom_range(0, 15)));
    for (int i = 0; i < 16; i++) begin
      send(DW'($urandom));
      collect("rand", 1, obs);
      if ($urandom_range(0, 1) == 1)
        write_coe(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
